// File: rtl/sram_burst_pkg.sv
// Shared types and sizing helpers for the SRAM burst controller.
// Define SRAM_RDATA_REG_EN to add one register stage on the macro read data.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_e;

`ifdef SRAM_RDATA_REG_EN
  localparam int unsigned RDATA_REG_STAGES = 1;
`else
  localparam int unsigned RDATA_REG_STAGES = 0;
`endif

  // One slot per beat that can be in flight, plus one so a beat can sit at the head.
  function automatic int unsigned fifo_depth(input int unsigned sram_lat);
    return sram_lat + 1 + RDATA_REG_STAGES;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Small circular FIFO for read beats; head is presented without a pop.
// Push and pop may happen in the same cycle, including when full.
module sram_rd_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Read/write burst controller driving a single-port SRAM macro.
// Define SRAM_RDATA_REG_EN to register sram_dout once before the read FIFO.
module sram_burst_ctrl
  import sram_burst_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned BURST_W  = 4,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_bm,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_bm,
  output logic              sram_men,
  output logic              sram_wen,
  output logic              sram_ren,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int unsigned RD_LAT = SRAM_LAT + RDATA_REG_STAGES;
  localparam int unsigned DEPTH  = fifo_depth(SRAM_LAT);
  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned REM_W  = BURST_W + 1;
  localparam int unsigned FIFO_W = DATA_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   bm_q, bm_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic [RD_LAT-1:0]   pend_vld_q;
  logic [RD_LAT-1:0]   pend_last_q;

  logic                accept, wr_fire, rd_issue, rd_pop, can_issue, last_beat;
  logic [CNT_W-1:0]    outst;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic [FIFO_W-1:0]   fifo_head;
  logic [DATA_W-1:0]   push_data;

  assign accept    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign wr_fire   = (state_q == WR) && wr_valid && wr_ready_q;
  assign last_beat = (rem_q == REM_W'(1));
  assign rd_pop    = rd_valid && rd_ready;

  // Reads still travelling through the macro (and the optional data register).
  always_comb begin
    outst = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      outst = outst + CNT_W'(pend_vld_q[i]);
    end
  end

  // A slot popped this cycle is free before any newly issued beat can land.
  assign can_issue = (SUM_W'(fifo_count) + SUM_W'(outst)) < (SUM_W'(DEPTH) + SUM_W'(rd_pop));
  assign rd_issue  = (state_q == RD) && can_issue;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    bm_d        = bm_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = cmd_addr;
          rem_d   = REM_W'(cmd_len) + REM_W'(1);
          bm_d    = cmd_bm;
          state_d = cmd_we ? WR : RD;
        end
      end
      WR: begin
        if (wr_fire) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - REM_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      RD: begin
        if (rd_issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - REM_W'(1);
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && (outst == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      bm_q        <= '0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      pend_vld_q  <= '0;
      pend_last_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      bm_q           <= bm_d;
      cmd_ready_q    <= cmd_ready_d;
      wr_ready_q     <= wr_ready_d;
      pend_vld_q[0]  <= rd_issue;
      pend_last_q[0] <= rd_issue && last_beat;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pend_vld_q[i]  <= pend_vld_q[i-1];
        pend_last_q[i] <= pend_last_q[i-1];
      end
    end
  end

`ifdef SRAM_RDATA_REG_EN
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= sram_dout;
    end
  end

  assign push_data = rdata_q;
`else
  assign push_data = sram_dout;
`endif

  sram_rd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pend_vld_q[RD_LAT-1]),
    .push_data_i ({pend_last_q[RD_LAT-1], push_data}),
    .pop_i       (rd_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = !fifo_empty;
  assign rd_data   = rd_valid ? fifo_head[DATA_W-1:0] : '0;
  assign rd_last   = rd_valid && fifo_head[DATA_W];
  assign busy      = (state_q != IDLE) || !fifo_empty;

  // Macro pins are quiet unless an access is issued this cycle.
  assign sram_men  = wr_fire || rd_issue;
  assign sram_wen  = wr_fire;
  assign sram_ren  = rd_issue;
  assign sram_addr = addr_q;
  assign sram_din  = wr_fire ? wr_data : '0;
  assign sram_bm   = wr_fire ? bm_q : '0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural single-port SRAM (latency 1).
module tb_sram_burst_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;
`ifdef SRAM_RDATA_REG_EN
  localparam int EXP_FIRST = 3;
  localparam int DEPTH     = 3;
`else
  localparam int EXP_FIRST = 2;
  localparam int DEPTH     = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_len;
  logic [DW-1:0] cmd_bm;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_bm;
  logic          sram_men, sram_wen, sram_ren;
  logic [DW-1:0] sram_dout = '0;

  sram_burst_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_bm    (cmd_bm),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_bm   (sram_bm),
    .sram_men  (sram_men),
    .sram_wen  (sram_wen),
    .sram_ren  (sram_ren),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural macro: bit-masked write, registered read data.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (sram_men && sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
    if (sram_men && sram_ren) sram_dout <= mem[sram_addr];
  end

  logic [AW-1:0] wlog[$];
  int            inflight = 0;
  int            max_inflight = 0;
  always @(posedge clk) begin
    if (rst) inflight = 0;
    else inflight = inflight + int'(sram_men && sram_ren) - int'(rd_valid && rd_ready);
    if (inflight > max_inflight) max_inflight = inflight;
    if (sram_men && sram_wen) wlog.push_back(sram_addr);
  end

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] rd_q[$];
  logic          last_q[$];
  int            first_cyc, last_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check_eq({pfx, "_wr_ready"},  64'(wr_ready),  64'd0);
    check_eq({pfx, "_rd_valid"},  64'(rd_valid),  64'd0);
    check_eq({pfx, "_rd_last"},   64'(rd_last),   64'd0);
    check_eq({pfx, "_busy"},      64'(busy),      64'd0);
    check_eq({pfx, "_men"},       64'(sram_men),  64'd0);
    check_eq({pfx, "_wen"},       64'(sram_wen),  64'd0);
    check_eq({pfx, "_ren"},       64'(sram_ren),  64'd0);
    check_eq({pfx, "_addr"},      64'(sram_addr), 64'd0);
    check_eq({pfx, "_din"},       64'(sram_din),  64'd0);
    check_eq({pfx, "_bm"},        64'(sram_bm),   64'd0);
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] len,
                          input logic [DW-1:0] bm);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_bm    = bm;
    for (int k = 0; k < 50 && !cmd_ready; k++) tick();
    check_eq("cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [BW-1:0] len,
                             input logic [DW-1:0] bm, input logic [DW-1:0] d[$]);
    wlog.delete();
    send_cmd(1'b1, a, len, bm);
    for (int b = 0; b <= int'(len); b++) begin
      wr_valid = 1'b1;
      wr_data  = d[b];
      for (int k = 0; k < 50 && !wr_ready; k++) tick();
      check_eq($sformatf("wr_ready_b%0d", b), 64'(wr_ready), 64'd1);
      tick();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    check_eq("wr_ready_drop", 64'(wr_ready), 64'd0);
    check_eq("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check_eq("wr_count", 64'(wlog.size()), 64'(int'(len) + 1));
    for (int b = 0; b < wlog.size(); b++) begin
      logic [AW-1:0] ea;
      ea = a + AW'(b);
      check_eq($sformatf("wr_addr_b%0d", b), 64'(wlog[b]), 64'(ea));
    end
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [BW-1:0] len, input logic [3:0] pat);
    rd_q.delete();
    last_q.delete();
    first_cyc    = -1;
    last_cyc     = -1;
    max_inflight = 0;
    send_cmd(1'b0, a, len, '0);
    for (int c = 0; c < 200 && rd_q.size() < int'(len) + 1; c++) begin
      rd_ready = pat[c % 4];
      if (rd_valid && first_cyc < 0) first_cyc = c;
      if (rd_valid && rd_ready) begin
        rd_q.push_back(rd_data);
        last_q.push_back(rd_last);
        last_cyc = c;
      end
      tick();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 50 && busy; k++) tick();
    check_eq("rd_beats", 64'(rd_q.size()), 64'(int'(len) + 1));
    check_eq("rd_busy_end", 64'(busy), 64'd0);
    check_eq("rd_inflight_bound", 64'(max_inflight <= DEPTH), 64'd1);
  endtask

  task automatic check_read(input string pfx, input logic [DW-1:0] exp[$]);
    for (int i = 0; i < exp.size() && i < rd_q.size(); i++) begin
      check_eq($sformatf("%s_data%0d", pfx, i), 64'(rd_q[i]), 64'(exp[i]));
      check_eq($sformatf("%s_last%0d", pfx, i), 64'(last_q[i]), 64'(i == exp.size() - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] da[$];
    logic [DW-1:0] db[$];
    logic [DW-1:0] dx[$];

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_bm = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    tick();
    tick();
    check_quiet("rst");
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Plain 4-beat write then back-to-back readback.
    da = '{32'hA000_00A0, 32'hA111_00A1, 32'hA222_00A2, 32'hA333_00A3};
    write_burst(10'h010, 4'd3, 32'hFFFF_FFFF, da);
    check_eq("idle_men", 64'(sram_men), 64'd0);
    read_burst(10'h010, 4'd3, 4'b1111);
    check_read("rd_full", da);
    check_eq("rd_first_lat", 64'(first_cyc), 64'(EXP_FIRST));
    check_eq("rd_back_to_back", 64'(last_cyc - first_cyc), 64'd3);

    // Backpressure pattern 1,0,0,1 repeating.
    read_burst(10'h010, 4'd3, 4'b1001);
    check_read("rd_bp", da);

    // Address wrap at the top of the array.
    db = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    write_burst(10'h3FE, 4'd3, 32'hFFFF_FFFF, db);
    read_burst(10'h3FE, 4'd3, 4'b1111);
    check_read("rd_wrap", db);

    // Partial bit mask merge.
    dx = '{32'h1234_5678};
    write_burst(10'h020, 4'd0, 32'hFFFF_FFFF, dx);
    dx = '{32'hDEAD_BEEF};
    write_burst(10'h020, 4'd0, 32'h0000_FFFF, dx);
    read_burst(10'h020, 4'd0, 4'b1111);
    dx = '{32'h1234_BEEF};
    check_read("rd_mask", dx);

    // Reset in the middle of a long read, then a fresh burst.
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 4'd15, '0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_quiet("mid_rst");
    rst = 1'b0;
    tick();
    read_burst(10'h010, 4'd1, 4'b1111);
    dx = '{32'hA000_00A0, 32'hA111_00A1};
    check_read("rd_after_rst", dx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
